mem_arbiter: RTL and testbench

// Two-client arbiter between the instruction cache, the data cache and the single main-memory port.

---
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between icache and dcache for one main-memory port,
// one transaction in flight, ownership held until read response or write data completes.
module mem_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ic_mem_req_valid,
    output logic                   ic_mem_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
    input  logic                   ic_mem_req_rw,
    input  logic                   ic_mem_req_data_valid,
    output logic                   ic_mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
    output logic                   ic_mem_resp_valid,
    output logic [DATA_BITS-1:0]   ic_mem_resp_data,
    input  logic                   dc_mem_req_valid,
    output logic                   dc_mem_req_ready,
    input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
    input  logic                   dc_mem_req_rw,
    input  logic                   dc_mem_req_data_valid,
    output logic                   dc_mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
    output logic                   dc_mem_resp_valid,
    output logic [DATA_BITS-1:0]   dc_mem_resp_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_DATA} state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d, last_q, last_d;
    logic   grant, sel, sel_dv, req_v, data_v, accept, data_fire, resp_hit;

    // on a tie the client opposite the last grant wins; a lone requester always wins
    assign grant  = (ic_mem_req_valid && dc_mem_req_valid) ? ~last_q : dc_mem_req_valid;
    assign sel    = (state_q == IDLE) ? grant : owner_q;
    assign sel_dv = sel ? dc_mem_req_data_valid : ic_mem_req_data_valid;

    assign req_v     = !reset && state_q == IDLE && (ic_mem_req_valid || dc_mem_req_valid);
    assign data_v    = !reset && ((state_q == WR_DATA) ? sel_dv : (req_v && mem_req_rw && sel_dv));
    assign accept    = req_v && mem_req_ready;
    assign data_fire = data_v && mem_req_data_ready && (state_q == WR_DATA || accept);
    assign resp_hit  = !reset && state_q == RD_WAIT && mem_resp_valid;

    assign mem_req_valid      = req_v;
    assign mem_req_data_valid = data_v;
    assign mem_req_addr       = sel ? dc_mem_req_addr : ic_mem_req_addr;
    assign mem_req_rw         = sel ? dc_mem_req_rw : ic_mem_req_rw;
    assign mem_req_data_bits  = sel ? dc_mem_req_data_bits : ic_mem_req_data_bits;
    assign mem_req_data_mask  = sel ? dc_mem_req_data_mask : ic_mem_req_data_mask;

    assign ic_mem_req_ready      = accept && !grant;
    assign dc_mem_req_ready      = accept && grant;
    assign ic_mem_req_data_ready = data_fire && !sel;
    assign dc_mem_req_data_ready = data_fire && sel;
    assign ic_mem_resp_valid     = resp_hit && !owner_q;
    assign dc_mem_resp_valid     = resp_hit && owner_q;
    assign ic_mem_resp_data      = mem_resp_data;
    assign dc_mem_resp_data      = mem_resp_data;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (accept) begin
            owner_d = grant;
            last_d  = grant;
            state_d = !mem_req_rw ? RD_WAIT : (data_fire ? IDLE : WR_DATA);
        end else if ((state_q == WR_DATA && data_fire) || resp_hit) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table for the multi-cycle scenarios, then random traffic
// checked against a transaction-queue reference model.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic ic_v, ic_rdy, ic_rw, ic_dv, ic_drdy, ic_rv, dc_v, dc_rdy, dc_rw, dc_dv, dc_drdy, dc_rv;
    logic [AW-1:0] ic_addr, dc_addr, m_addr;
    logic [DW-1:0] ic_bits, dc_bits, ic_rdata, dc_rdata, m_bits, m_rdata;
    logic [MW-1:0] ic_mask, dc_mask, m_mask;
    logic m_v, m_rdy, m_rw, m_dv, m_drdy, m_rspv;

    mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk(clk), .reset(reset),
        .ic_mem_req_valid(ic_v), .ic_mem_req_ready(ic_rdy), .ic_mem_req_addr(ic_addr),
        .ic_mem_req_rw(ic_rw), .ic_mem_req_data_valid(ic_dv), .ic_mem_req_data_ready(ic_drdy),
        .ic_mem_req_data_bits(ic_bits), .ic_mem_req_data_mask(ic_mask),
        .ic_mem_resp_valid(ic_rv), .ic_mem_resp_data(ic_rdata),
        .dc_mem_req_valid(dc_v), .dc_mem_req_ready(dc_rdy), .dc_mem_req_addr(dc_addr),
        .dc_mem_req_rw(dc_rw), .dc_mem_req_data_valid(dc_dv), .dc_mem_req_data_ready(dc_drdy),
        .dc_mem_req_data_bits(dc_bits), .dc_mem_req_data_mask(dc_mask),
        .dc_mem_resp_valid(dc_rv), .dc_mem_resp_data(dc_rdata),
        .mem_req_valid(m_v), .mem_req_ready(m_rdy), .mem_req_addr(m_addr), .mem_req_rw(m_rw),
        .mem_req_data_valid(m_dv), .mem_req_data_ready(m_drdy),
        .mem_req_data_bits(m_bits), .mem_req_data_mask(m_mask),
        .mem_resp_valid(m_rspv), .mem_resp_data(m_rdata)
    );

    int applied = 0;
    int miscompares = 0;

    // inputs: {rst, icv, icrw, icdv, dcv, dcrw, dcdv, mrdy, mdrdy, mresp}
    // ctrl:   {mem_req_valid, mem_req_data_valid, ic_req_ready, dc_req_ready,
    //          ic_data_ready, dc_data_ready, ic_resp_valid, dc_resp_valid}
    typedef struct {
        logic [9:0] in;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[$];

    typedef struct {
        bit owner;
        bit wr;
    } txn_t;
    txn_t pend[$];
    bit m_last = 1'b0;
    bit win, acc, fired, w_rw;
    logic [7:0] exp_ctrl;

    function automatic void add(input logic [9:0] in, input logic [7:0] exp);
        vec_t v;
        v.in = in;
        v.exp = exp;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] v);
        {reset, ic_v, ic_rw, ic_dv, dc_v, dc_rw, dc_dv, m_rdy, m_drdy, m_rspv} = v;
    endtask

    // expected outputs from the outstanding-transaction queue and the current inputs
    task automatic model_eval();
        bit d, o;
        exp_ctrl = '0;
        acc = 0;
        fired = 0;
        win = 0;
        w_rw = 0;
        if (reset) return;
        if (pend.size() == 0) begin
            win = (ic_v && dc_v) ? !m_last : dc_v;
            if (ic_v || dc_v) begin
                w_rw = win ? dc_rw : ic_rw;
                d = win ? dc_dv : ic_dv;
                exp_ctrl[7] = 1;
                exp_ctrl[6] = w_rw && d;
                acc = m_rdy;
                fired = acc && exp_ctrl[6] && m_drdy;
                exp_ctrl[win ? 4 : 5] = acc;
                exp_ctrl[win ? 2 : 3] = fired;
            end
        end else begin
            o = pend[0].owner;
            if (pend[0].wr) begin
                d = o ? dc_dv : ic_dv;
                exp_ctrl[6] = d;
                exp_ctrl[o ? 2 : 3] = d && m_drdy;
            end else begin
                exp_ctrl[o ? 0 : 1] = m_rspv;
            end
        end
    endtask

    task automatic model_update();
        txn_t t;
        if (reset) begin
            pend.delete();
            m_last = 0;
        end else if (pend.size() == 0) begin
            if (acc) begin
                m_last = win;
                t.owner = win;
                t.wr = w_rw;
                if (!w_rw || !fired) pend.push_back(t);
            end
        end else if (pend[0].wr) begin
            if (exp_ctrl[6] && m_drdy) void'(pend.pop_front());
        end else if (m_rspv) begin
            void'(pend.pop_front());
        end
    endtask

    task automatic cycle(input bit use_tbl, input logic [7:0] texp);
        bit o;
        @(negedge clk);
        model_eval();
        check("ctrl", DW'({m_v, m_dv, ic_rdy, dc_rdy, ic_drdy, dc_drdy, ic_rv, dc_rv}),
              DW'(use_tbl ? texp : exp_ctrl));
        o = (pend.size() == 0) ? win : pend[0].owner;
        if (exp_ctrl[7]) begin
            check("addr", DW'(m_addr), DW'(win ? dc_addr : ic_addr));
            check("rw", DW'(m_rw), DW'(win ? dc_rw : ic_rw));
        end
        if (exp_ctrl[6]) begin
            check("wdata", m_bits, o ? dc_bits : ic_bits);
            check("wmask", DW'(m_mask), DW'(o ? dc_mask : ic_mask));
        end
        if (|exp_ctrl[1:0]) check("rdata", o ? dc_rdata : ic_rdata, m_rdata);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        drive(10'b1000000000);
        ic_addr = 28'h0000010;
        dc_addr = 28'h00000A4;
        ic_bits = {4{32'h11112222}};
        dc_bits = {96'h0, 32'hDEADBEEF};
        ic_mask = 16'h00FF;
        dc_mask = 16'hFFFF;
        m_rdata = {4{32'hCAFEF00D}};
        // ic read, response three cycles later
        add(10'b1100000100, 8'b00000000);
        add(10'b0100000100, 8'b10100000);
        add(10'b0000000100, 8'b00000000);
        add(10'b0000000000, 8'b00000000);
        add(10'b0000000001, 8'b00000010);
        // tie after reset: dc, then ic, then dc
        add(10'b1000000000, 8'b00000000);
        add(10'b0100100100, 8'b10010000);
        add(10'b0100100100, 8'b00000000);
        add(10'b0100100001, 8'b00000001);
        add(10'b0100000100, 8'b10100000);
        add(10'b0000000001, 8'b00000010);
        add(10'b0100100100, 8'b10010000);
        add(10'b0000000001, 8'b00000001);
        // dc write, memory withholds data_ready two cycles
        add(10'b0000111100, 8'b11010000);
        add(10'b0100001100, 8'b01000000);
        add(10'b0100001100, 8'b01000000);
        add(10'b0100001110, 8'b01000100);
        add(10'b0100000100, 8'b10100000);
        add(10'b0000000001, 8'b00000010);
        // ic stalled behind a dc read
        add(10'b0000100100, 8'b10010000);
        add(10'b0100000100, 8'b00000000);
        add(10'b0100000100, 8'b00000000);
        add(10'b0100000101, 8'b00000001);
        add(10'b0100000100, 8'b10100000);
        add(10'b0000000001, 8'b00000010);
        // memory not ready for four cycles
        add(10'b0100000000, 8'b10000000);
        add(10'b0100000000, 8'b10000000);
        add(10'b0100000000, 8'b10000000);
        add(10'b0100000000, 8'b10000000);
        add(10'b0100000100, 8'b10100000);
        add(10'b0000000001, 8'b00000010);
        // ic write with data in the same cycle
        add(10'b0111000110, 8'b11101000);
        // reset during a dc read drops the late response
        add(10'b0000100100, 8'b10010000);
        add(10'b1000000000, 8'b00000000);
        add(10'b0000000001, 8'b00000000);
        add(10'b0100000100, 8'b10100000);
        add(10'b0000000001, 8'b00000010);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].in);
            cycle(1'b1, tbl[i].exp);
        end

        for (int n = 0; n < 1500; n++) begin
            reset   = ($urandom % 64) == 0;
            ic_v    = $urandom % 2;
            dc_v    = $urandom % 2;
            ic_rw   = $urandom % 2;
            dc_rw   = $urandom % 2;
            ic_dv   = ($urandom % 4) != 0;
            dc_dv   = ($urandom % 4) != 0;
            ic_addr = AW'($urandom);
            dc_addr = AW'($urandom);
            ic_bits = {$urandom, $urandom, $urandom, $urandom};
            dc_bits = {$urandom, $urandom, $urandom, $urandom};
            ic_mask = MW'($urandom);
            dc_mask = MW'($urandom);
            m_rdy   = ($urandom % 4) != 0;
            m_drdy  = $urandom % 2;
            m_rspv  = (pend.size() != 0 && !pend[0].wr) ? ($urandom % 3) == 0 : ($urandom % 16) == 0;
            m_rdata = {$urandom, $urandom, $urandom, $urandom};
            cycle(1'b0, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
